// File: rtl/xor_vec_unit.sv
// Single-stage registered XOR of two operands with valid/ready handshake.
// Registers the XOR vector together with its Hamming weight, parity and zero flag.
module xor_vec_unit #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] n1,
    input  logic [WIDTH-1:0] n2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic [CW-1:0]    weight,
    output logic             parity,
    output logic             zero
);

    logic [WIDTH-1:0] w_x;
    logic [CW-1:0]    w_weight;
    logic             w_accept;

    logic             r_valid;
    logic [WIDTH-1:0] r_x;
    logic [CW-1:0]    r_weight;
    logic             r_parity;
    logic             r_zero;

    assign w_x      = n1 ^ n2;
    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_weight = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_weight = w_weight + CW'(w_x[i]);
        end
    end

    // All four result registers load together so they always describe one operand pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_x      <= '0;
            r_weight <= '0;
            r_parity <= 1'b0;
            r_zero   <= 1'b1;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_x      <= w_x;
            r_weight <= w_weight;
            r_parity <= ^w_x;
            r_zero   <= (w_x == '0);
        end else if (out_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign x         = r_x;
    assign weight    = r_weight;
    assign parity    = r_parity;
    assign zero      = r_zero;

endmodule

// File: tb/tb_xor_vec_unit.sv
// Directed and random stimulus for xor_vec_unit, checked against a transaction-level
// model that tracks only the held result and whether it is still pending.
module tb_xor_vec_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] n1;
    logic [3:0] n2;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] x;
    logic [2:0] weight;
    logic       parity;
    logic       zero;

    int total = 0;
    int bad   = 0;

    // Model state: the result currently presented and whether it is valid.
    logic       m_valid;
    logic [3:0] m_x;

    xor_vec_unit #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .n1       (n1),
        .n2       (n2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x        (x),
        .weight   (weight),
        .parity   (parity),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int popcount(int v);
        int c = 0;
        while (v != 0) begin
            c += v % 2;
            v  = v / 2;
        end
        return c;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        int w;
        w = popcount(int'(m_x));
        chk({tag, ".out_valid"}, int'(out_valid), int'(m_valid));
        chk({tag, ".x"},         int'(x),         int'(m_x));
        chk({tag, ".weight"},    int'(weight),    w);
        chk({tag, ".parity"},    int'(parity),    w % 2);
        chk({tag, ".zero"},      int'(zero),      (m_x == 4'd0) ? 1 : 0);
    endtask

    // One cycle: drive at negedge, check in_ready, clock, advance model, check results.
    task automatic step(input string tag, input logic v, input logic [3:0] a,
                        input logic [3:0] b, input logic ordy);
        int exp_rdy;
        @(negedge clk);
        in_valid  = v;
        n1        = a;
        n2        = b;
        out_ready = ordy;
        #1;
        exp_rdy = (!m_valid || ordy) ? 1 : 0;
        chk({tag, ".in_ready"}, int'(in_ready), exp_rdy);
        @(posedge clk);
        if (v && exp_rdy == 1) begin
            m_x     = a ^ b;
            m_valid = 1'b1;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        #1;
        chk_outputs(tag);
    endtask

    initial begin
        // Reset with a valid pair presented: nothing may be captured.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        n1        = 4'b1010;
        n2        = 4'b0101;
        out_ready = 1'b1;
        m_valid   = 1'b0;
        m_x       = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs("reset");
        chk("reset.in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        step("first", 1'b1, 4'b1010, 4'b0101, 1'b1);
        chk("first.weight4", int'(weight), 4);

        // Exhaustive sweep at full throughput.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                step("sweep", 1'b1, 4'(a), 4'(b), 1'b1);
            end
        end

        step("eq", 1'b1, 4'b1111, 4'b1111, 1'b1);
        chk("eq.zero", int'(zero), 1);
        step("one", 1'b1, 4'b0001, 4'b0000, 1'b1);
        chk("one.parity", int'(parity), 1);

        // Backpressure: result must hold while inputs churn.
        step("bp.acc", 1'b1, 4'b1100, 4'b1010, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step("bp.stall", 1'b1, 4'($urandom), 4'($urandom), 1'b0);
            chk("bp.hold", int'(x), 6);
        end
        step("bp.release", 1'b1, 4'b0011, 4'b0110, 1'b1);
        chk("bp.valid", int'(out_valid), 1);

        // Bubble: output drains, value retained.
        step("bubble", 1'b0, 4'b1111, 4'b0000, 1'b1);
        chk("bubble.x", int'(x), 5);

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
                 1'($urandom_range(0, 2) != 0));
        end

        // Asynchronous reset while a result is stalled.
        step("ar.acc", 1'b1, 4'b1001, 4'b0100, 1'b0);
        step("ar.stall", 1'b1, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        #2;
        rst_n   = 1'b0;
        m_valid = 1'b0;
        m_x     = 4'd0;
        #1;
        chk_outputs("async_rst");
        chk("async_rst.in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        chk_outputs("async_rst.hold");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst.idle", 1'b0, 4'b1111, 4'b0000, 1'b1);
        step("post_rst", 1'b1, 4'b0110, 4'b0101, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
